// File: rtl/button_input_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// button_input_conditioner_pkg
//
// Shared definitions for the pushbutton conditioning path:
//   - btn_state_t : one-hot encoding of the per-button debounce/repeat FSM
//   - BTN_*       : bit positions of each board pushbutton in the button bus
// No ports; imported by btn_debounce_fsm and button_input_conditioner.
// ---------------------------------------------------------------------------
package button_input_conditioner_pkg;

  // One-hot state encoding. Each output is a simple OR of state bits.
  typedef enum logic [5:0] {
    INI     = 6'b000001,
    WQ      = 6'b000010,
    SCEN_ST = 6'b000100,
    CCR     = 6'b001000,
    MCEN_ST = 6'b010000,
    WFCR    = 6'b100000
  } btn_state_t;

  // Bit positions of the physical buttons in the N_BTN-wide buses.
  localparam int BTN_C = 0;
  localparam int BTN_L = 1;
  localparam int BTN_R = 2;
  localparam int BTN_U = 3;
  localparam int BTN_D = 4;

endpackage

// File: rtl/button_input_conditioner_btn_debounce_fsm.sv
// ---------------------------------------------------------------------------
// btn_debounce_fsm
//
// One pushbutton: two-flop synchronizer, debounce/auto-repeat FSM and its
// timer. All outputs are a Moore decode of the registered state.
//
// Ports:
//   i_clk     : system clock
//   i_rst     : synchronous active-high reset
//   i_btn_raw : asynchronous raw button level, 1 = pressed
//   o_level   : debounced level
//   o_scen    : one-clock pulse per debounced press
//   o_mcen    : pulse at press, then one every RPT_CNT+1 clocks while held
//   o_ccen    : high every clock from the press until release is detected
// ---------------------------------------------------------------------------
module btn_debounce_fsm
  import button_input_conditioner_pkg::*;
#(
  parameter int DEB_CNT = 1000000,
  parameter int RPT_CNT = 50000000,
  parameter int CNT_W   = 26
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_raw,
  output logic o_level,
  output logic o_scen,
  output logic o_mcen,
  output logic o_ccen
);

  // Terminal counts are compared against the timer directly, so the
  // timer never has to count beyond the larger of the two windows.
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CNT - 1);
  localparam logic [CNT_W-1:0] RPT_LAST = CNT_W'(RPT_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_sync1;
  logic             r_sync2;
  logic             w_pb;
  btn_state_t       r_state;
  btn_state_t       w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;

  // Two-flop synchronizer bringing the asynchronous button into the clock
  // domain. Cleared on reset so a held button must be re-qualified.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_pb = r_sync2;

  // State and timer registers. Reset drops straight to INI with a cleared
  // timer, even in the middle of a press.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= INI;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
    end
  end

  // Next-state and timer logic. The press must stay high for a full
  // debounce window before it is accepted, the repeat timer runs while held,
  // and the release must stay low for a full debounce window before the
  // button is considered idle again. Release is checked before the repeat
  // timer so a release on the expiry clock never produces a repeat pulse.
  // The two pulse states last one clock and ignore the input.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    unique case (r_state)
      INI: begin
        if (w_pb) begin
          w_state_next = WQ;
          w_cnt_next   = '0;
        end
      end
      WQ: begin
        if (!w_pb) begin
          w_state_next = INI;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = SCEN_ST;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      SCEN_ST: begin
        w_state_next = CCR;
        w_cnt_next   = '0;
      end
      CCR: begin
        if (!w_pb) begin
          w_state_next = WFCR;
          w_cnt_next   = '0;
        end else if (r_cnt == RPT_LAST) begin
          w_state_next = MCEN_ST;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      MCEN_ST: begin
        w_state_next = CCR;
        w_cnt_next   = '0;
      end
      WFCR: begin
        if (w_pb) begin
          w_state_next = CCR;
          w_cnt_next   = '0;
        end else if (r_cnt == DEB_LAST) begin
          w_state_next = INI;
        end else begin
          w_cnt_next = r_cnt + CNT_ONE;
        end
      end
      default: begin
        w_state_next = INI;
        w_cnt_next   = '0;
      end
    endcase
  end

  // Moore output decode from the registered state only.
  assign o_scen  = (r_state == SCEN_ST);
  assign o_mcen  = (r_state == SCEN_ST) || (r_state == MCEN_ST);
  assign o_ccen  = (r_state == SCEN_ST) || (r_state == CCR) || (r_state == MCEN_ST);
  assign o_level = (r_state == SCEN_ST) || (r_state == CCR) ||
                   (r_state == MCEN_ST) || (r_state == WFCR);

endmodule

// File: rtl/button_input_conditioner.sv
// ---------------------------------------------------------------------------
// button_input_conditioner
//
// Turns the raw board pushbuttons into clean, synchronized, debounced
// controls and single-clock enables for the camera, weapon and enemy
// controllers. Each button has its own independent btn_debounce_fsm.
//
// Ports:
//   i_clk       : system clock (100 MHz)
//   i_rst       : synchronous active-high reset
//   i_btn_raw   : raw button levels, bit 0=C 1=L 2=R 3=U 4=D, 1 = pressed
//   o_btn_level : debounced levels
//   o_btn_scen  : one pulse per debounced press
//   o_btn_mcen  : pulse at press, then every RPT_CNT+1 clocks while held
//   o_btn_ccen  : high every clock from press until release is detected
// ---------------------------------------------------------------------------
module button_input_conditioner
  import button_input_conditioner_pkg::*;
#(
  parameter int N_BTN   = 5,
  parameter int DEB_CNT = 1000000,
  parameter int RPT_CNT = 50000000,
  parameter int CNT_W   = 26
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [N_BTN-1:0] i_btn_raw,
  output logic [N_BTN-1:0] o_btn_level,
  output logic [N_BTN-1:0] o_btn_scen,
  output logic [N_BTN-1:0] o_btn_mcen,
  output logic [N_BTN-1:0] o_btn_ccen
);

  // Largest value the per-button timer can represent.
  localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;

  // Reject parameter sets the timer cannot represent, or a repeat period
  // too short to leave room for the pulse state.
  generate
    if (N_BTN < 1) begin : g_bad_n_btn
      $error("button_input_conditioner: N_BTN must be at least 1");
    end
    if (longint'(DEB_CNT) < 1 || longint'(DEB_CNT) > CNT_MAX) begin : g_bad_deb
      $error("button_input_conditioner: DEB_CNT out of range for CNT_W");
    end
    if (longint'(RPT_CNT) < 2 || longint'(RPT_CNT) > CNT_MAX) begin : g_bad_rpt
      $error("button_input_conditioner: RPT_CNT out of range for CNT_W");
    end
  endgenerate

  // One fully independent conditioner per button.
  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    btn_debounce_fsm #(
      .DEB_CNT(DEB_CNT),
      .RPT_CNT(RPT_CNT),
      .CNT_W  (CNT_W)
    ) u_fsm (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_btn_raw(i_btn_raw[g]),
      .o_level  (o_btn_level[g]),
      .o_scen   (o_btn_scen[g]),
      .o_mcen   (o_btn_mcen[g]),
      .o_ccen   (o_btn_ccen[g])
    );
  end

endmodule
